// File: rtl/bislm_pkg.sv
// Shared definitions for the skew measurement core: FSM state encoding,
// default widths, the saturation constant and the stamp-slice helper.
package bislm_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 8;
  localparam int CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } sc_state_t;

  // LSB position of channel ch inside the packed stamp bus.
  function automatic int stamp_lsb(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/skew_stamp_reg.sv
// One channel's arrival record: a captured flag plus the cycle stamp taken
// when the flag was set. Clear drops the flag only; the stamp stays visible.
module skew_stamp_reg #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_captured,
  output logic [CNT_W-1:0] o_stamp
);

  logic             r_captured;
  logic [CNT_W-1:0] r_stamp;

  // Flag/stamp update; clear wins over capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_captured <= 1'b0;
      r_stamp    <= '0;
    end else if (i_clear) begin
      r_captured <= 1'b0;
    end else if (i_capture) begin
      r_captured <= 1'b1;
      r_stamp    <= i_val;
    end
  end

  assign o_captured = r_captured;
  assign o_stamp    = r_stamp;

endmodule

// File: rtl/skew_counter.sv
// Arrival-skew measurement core. Timestamps each latched channel relative to
// the first arrival, hands the result downstream over valid/ready, then holds
// the latch stage in reset until every flag reads back low.
// Optional feature macro: SKEW_MAXHOLD_EN adds SC_SKEW_MAX, the largest skew
// transferred since reset.
module skew_counter
  import bislm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  SC_CLK,
  input  logic                  SC_RST,
  input  logic [N_CH-1:0]       SC_Q,
  input  logic                  SC_READY,
  output logic                  SC_VALID,
  output logic [CNT_W-1:0]      SC_SKEW,
  output logic [N_CH*CNT_W-1:0] SC_STAMP,
  output logic [N_CH-1:0]       SC_MISS,
  output logic                  SC_TIMEOUT,
  output logic                  SC_LN_RST,
`ifdef SKEW_MAXHOLD_EN
  output logic [CNT_W-1:0]      SC_SKEW_MAX,
`endif
  output logic                  SC_BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sc_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_skew;
  logic [N_CH-1:0]  r_miss;
  logic             r_timeout;
  logic             r_valid;
  logic             r_ln_rst;
  logic             r_busy;

  sc_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_skew_nxt;
  logic [N_CH-1:0]  w_miss_nxt;
  logic             w_timeout_nxt;
  logic             w_valid_nxt;
  logic             w_ln_rst_nxt;
  logic [N_CH-1:0]  w_cap;
  logic [N_CH-1:0]  w_clr;
  logic [CNT_W-1:0] w_stamp_val;
  logic [N_CH-1:0]  w_captured;
  logic [N_CH-1:0]  w_seen;
  logic             w_xfer;

  assign w_seen = w_captured | SC_Q;
  assign w_xfer = (r_state == ST_DONE) && r_valid && SC_READY;

  // Next-state and next-output decode for the measurement FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_skew_nxt    = r_skew;
    w_miss_nxt    = r_miss;
    w_timeout_nxt = r_timeout;
    w_valid_nxt   = r_valid;
    w_ln_rst_nxt  = r_ln_rst;
    w_cap         = '0;
    w_clr         = '0;
    w_stamp_val   = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (|SC_Q) begin
          // First arrivals define time zero; idle channels start unseen.
          w_cap       = SC_Q;
          w_clr       = ~SC_Q;
          w_stamp_val = '0;
          w_cnt_nxt   = CNT_W'(1);
          if (&SC_Q) begin
            w_skew_nxt  = '0;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_COUNT;
          end
        end
      end

      ST_COUNT: begin
        w_cap = SC_Q & ~w_captured;
        if (&w_seen) begin
          w_skew_nxt  = r_cnt;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_MAX) begin
          // r_cnt is already CNT_MAX, so every unseen channel is stamped with it.
          w_cap         = ~w_captured;
          w_timeout_nxt = 1'b1;
          w_skew_nxt    = CNT_MAX;
          w_miss_nxt    = ~w_seen;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        if (w_xfer) begin
          w_valid_nxt  = 1'b0;
          w_ln_rst_nxt = 1'b1;
          w_state_nxt  = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        // Latch reset is registered and set has priority, so wait for all-zero.
        if (SC_Q == '0) begin
          w_ln_rst_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
          w_miss_nxt    = '0;
          w_cnt_nxt     = '0;
          w_clr         = '1;
          w_state_nxt   = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // State and registered-output update; reset forces CLEAR to flush stale latches.
  always_ff @(posedge SC_CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (SC_RST) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      r_skew    <= '0;
      r_miss    <= '0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
      r_ln_rst  <= 1'b1;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_skew    <= w_skew_nxt;
      r_miss    <= w_miss_nxt;
      r_timeout <= w_timeout_nxt;
      r_valid   <= w_valid_nxt;
      r_ln_rst  <= w_ln_rst_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam int LSB = stamp_lsb(g, CNT_W);

    skew_stamp_reg #(.CNT_W(CNT_W)) u_stamp (
      .i_clk      (SC_CLK),
      .i_rst      (SC_RST),
      .i_clear    (w_clr[g]),
      .i_capture  (w_cap[g]),
      .i_val      (w_stamp_val),
      .o_captured (w_captured[g]),
      .o_stamp    (SC_STAMP[LSB +: CNT_W])
    );
  end

`ifdef SKEW_MAXHOLD_EN
  logic [CNT_W-1:0] r_skew_max;

  // Running maximum of transferred skews; only reset clears it.
  always_ff @(posedge SC_CLK) begin
    if (SC_RST) begin
      r_skew_max <= '0;
    end else if (w_xfer && (r_skew > r_skew_max)) begin
      r_skew_max <= r_skew;
    end
  end

  assign SC_SKEW_MAX = r_skew_max;
`endif

  assign SC_VALID   = r_valid;
  assign SC_SKEW    = r_skew;
  assign SC_MISS    = r_miss;
  assign SC_TIMEOUT = r_timeout;
  assign SC_LN_RST  = r_ln_rst;
  assign SC_BUSY    = r_busy;

endmodule

// File: tb/tb_skew_counter.sv
// Directed bench for skew_counter at N_CH=4, CNT_W=4 (CNT_MAX=15).
// Inputs change and outputs are sampled just after the falling edge.
module tb_skew_counter;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       q;
  logic                  ready;
  logic                  valid;
  logic [CNT_W-1:0]      skew;
  logic [N_CH*CNT_W-1:0] stamp;
  logic [N_CH-1:0]       miss;
  logic                  timeout;
  logic                  ln_rst;
  logic                  busy;
`ifdef SKEW_MAXHOLD_EN
  logic [CNT_W-1:0]      skew_max;
`endif

  always #5 clk = ~clk;

  skew_counter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .SC_CLK      (clk),
    .SC_RST      (rst),
    .SC_Q        (q),
    .SC_READY    (ready),
    .SC_VALID    (valid),
    .SC_SKEW     (skew),
    .SC_STAMP    (stamp),
    .SC_MISS     (miss),
    .SC_TIMEOUT  (timeout),
    .SC_LN_RST   (ln_rst),
`ifdef SKEW_MAXHOLD_EN
    .SC_SKEW_MAX (skew_max),
`endif
    .SC_BUSY     (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  q;
    logic        ready;
    logic        valid;
    logic [3:0]  skew;
    logic        ln_rst;
    logic        busy;
    logic        timeout;
    logic [3:0]  miss;
    logic [15:0] stamp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic [3:0] qq, input logic rd);
    rst   = r;
    q     = qq;
    ready = rd;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [3:0] sk,
                           input logic ln, input logic bz, input logic to,
                           input logic [3:0] ms, input logic [15:0] st);
    check({tag, ".valid"},   32'(valid),   32'(v));
    check({tag, ".skew"},    32'(skew),    32'(sk));
    check({tag, ".ln_rst"},  32'(ln_rst),  32'(ln));
    check({tag, ".busy"},    32'(busy),    32'(bz));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
    check({tag, ".miss"},    32'(miss),    32'(ms));
    check({tag, ".stamp"},   32'(stamp),   32'(st));
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] qq, input logic rd,
                              input logic v, input logic [3:0] sk, input logic ln,
                              input logic bz, input logic to, input logic [3:0] ms,
                              input logic [15:0] st);
    vec_t t;
    t.rst = r; t.q = qq; t.ready = rd; t.valid = v; t.skew = sk;
    t.ln_rst = ln; t.busy = bz; t.timeout = to; t.miss = ms; t.stamp = st;
    return t;
  endfunction

  // One complete measurement: ch0 first, the rest k cycles later, then transfer and clear.
  task automatic measure(input int k);
    step(1'b0, 4'b0001, 1'b0);
    for (int i = 1; i < k; i++) step(1'b0, 4'b0001, 1'b0);
    check("meas.valid_before", 32'(valid), 32'd0);
    step(1'b0, 4'b1111, 1'b0);
    check("meas.valid", 32'(valid), 32'd1);
    check("meas.skew",  32'(skew),  32'(k));
    step(1'b0, 4'b1111, 1'b1);
    check("meas.xfer_valid", 32'(valid), 32'd0);
    step(1'b0, 4'b0000, 1'b0);
    check("meas.idle_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    rst = 1'b1; q = '0; ready = 1'b0;

    //                 rst q        rdy  v  sk    ln bz to miss     stamp
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 0, 4'd0, 1, 1, 0, 4'b0000, 16'h0000);
    vecs[1]  = mk(1'b0, 4'b0000, 1'b0, 0, 4'd0, 0, 0, 0, 4'b0000, 16'h0000);
    vecs[2]  = mk(1'b0, 4'b0000, 1'b0, 0, 4'd0, 0, 0, 0, 4'b0000, 16'h0000);
    // All four channels together: result on the very next edge, skew 0.
    vecs[3]  = mk(1'b0, 4'b1111, 1'b0, 1, 4'd0, 0, 1, 0, 4'b0000, 16'h0000);
    vecs[4]  = mk(1'b0, 4'b1111, 1'b0, 1, 4'd0, 0, 1, 0, 4'b0000, 16'h0000);
    vecs[5]  = mk(1'b0, 4'b1111, 1'b1, 0, 4'd0, 1, 1, 0, 4'b0000, 16'h0000);
    vecs[6]  = mk(1'b0, 4'b1111, 1'b0, 0, 4'd0, 1, 1, 0, 4'b0000, 16'h0000);
    vecs[7]  = mk(1'b0, 4'b0000, 1'b0, 0, 4'd0, 0, 0, 0, 4'b0000, 16'h0000);
    // Staggered: ch0 at t, ch2 at t+3, ch1 at t+5, ch3 at t+7.
    vecs[8]  = mk(1'b0, 4'b0001, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0000);
    vecs[9]  = mk(1'b0, 4'b0001, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0000);
    vecs[10] = mk(1'b0, 4'b0001, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0000);
    vecs[11] = mk(1'b0, 4'b0101, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0300);
    vecs[12] = mk(1'b0, 4'b0101, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0300);
    vecs[13] = mk(1'b0, 4'b0111, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0350);
    vecs[14] = mk(1'b0, 4'b0111, 1'b0, 0, 4'd0, 0, 1, 0, 4'b0000, 16'h0350);
    vecs[15] = mk(1'b0, 4'b1111, 1'b0, 1, 4'd7, 0, 1, 0, 4'b0000, 16'h7350);
    vecs[16] = mk(1'b0, 4'b1111, 1'b1, 0, 4'd7, 1, 1, 0, 4'b0000, 16'h7350);
    vecs[17] = mk(1'b0, 4'b0000, 1'b0, 0, 4'd7, 0, 0, 0, 4'b0000, 16'h7350);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].q, vecs[i].ready);
      check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].skew, vecs[i].ln_rst,
                vecs[i].busy, vecs[i].timeout, vecs[i].miss, vecs[i].stamp);
    end
`ifdef SKEW_MAXHOLD_EN
    check("max.after_first", 32'(skew_max), 32'd7);
`endif

    // Timeout: only ch3 ever arrives; result after 15 cycles.
    step(1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 4'b1000, 1'b0);
    check_all("to.pre", 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 4'b0000, 16'h0350);
    step(1'b0, 4'b1000, 1'b0);
    check_all("to.done", 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 4'b0111, 16'h0FFF);

    // Stall with READY low while SC_Q wanders: results must not move.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'((i * 7 + 3) & 15), 1'b0);
      check_all($sformatf("stall%0d", i), 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 4'b0111, 16'h0FFF);
    end

    // One-cycle transfer, then CLEAR holds while a flag is still set.
    step(1'b0, 4'b1010, 1'b1);
    check_all("xfer", 1'b0, 4'd15, 1'b1, 1'b1, 1'b1, 4'b0111, 16'h0FFF);
    step(1'b0, 4'b1010, 1'b0);
    check_all("clr.hold", 1'b0, 4'd15, 1'b1, 1'b1, 1'b1, 4'b0111, 16'h0FFF);
    step(1'b0, 4'b0000, 1'b0);
    check_all("clr.exit", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0FFF);
`ifdef SKEW_MAXHOLD_EN
    check("max.after_timeout", 32'(skew_max), 32'd15);
`endif

    // Reset mid-COUNT discards the measurement.
    step(1'b0, 4'b0101, 1'b0);
    step(1'b0, 4'b0101, 1'b0);
    check("rst.counting", 32'(busy), 32'd1);
    step(1'b1, 4'b0101, 1'b0);
    check_all("rst.pulse", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000);
`ifdef SKEW_MAXHOLD_EN
    check("max.after_rst", 32'(skew_max), 32'd0);
`endif
    step(1'b0, 4'b0101, 1'b0);
    check_all("rst.clear", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000);
    step(1'b0, 4'b0000, 1'b0);
    check_all("rst.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, 1'b0);
      check($sformatf("rst.novalid%0d", i), 32'(valid), 32'd0);
    end

    // Two measurements, larger skew first; the running max keeps the larger.
    measure(7);
    measure(3);
`ifdef SKEW_MAXHOLD_EN
    check("max.7then3", 32'(skew_max), 32'd7);
    step(1'b1, 4'b0000, 1'b0);
    check("max.cleared", 32'(skew_max), 32'd0);
    step(1'b0, 4'b0000, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
